// File: rtl/wb_axi_rd_bridge_if.sv
// Wishbone read-slave and AXI4 read-master signal bundle for wb_axi_rd_bridge.
// The bridge takes the slave modport; the surrounding system takes master.
`timescale 1ns/1ps
interface wb_axi_rd_bridge_if #(
  parameter int ADDR_WIDTH = 28
);
  logic [ADDR_WIDTH-1:0] wbs_adr;
  logic [31:0]           wbs_dat_w;
  logic [31:0]           wbs_dat_r;
  logic [3:0]            wbs_sel;
  logic                  wbs_we;
  logic                  wbs_cyc;
  logic                  wbs_stb;
  logic                  wbs_stall;
  logic                  wbs_ack;
  logic                  wbs_err;

  logic [31:0]           m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic [2:0]            m_axi_arprot;
  logic [3:0]            m_axi_arcache;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [31:0]           m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport slave (
    input  wbs_adr, wbs_dat_w, wbs_sel, wbs_we, wbs_cyc, wbs_stb,
    output wbs_dat_r, wbs_stall, wbs_ack, wbs_err,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arprot, m_axi_arcache, m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport master (
    output wbs_adr, wbs_dat_w, wbs_sel, wbs_we, wbs_cyc, wbs_stb,
    input  wbs_dat_r, wbs_stall, wbs_ack, wbs_err,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arprot, m_axi_arcache, m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );
endinterface

// File: rtl/wb_axi_rd_bridge.sv
// Pipelined Wishbone read slave issuing single-beat AXI4 reads, up to
// OUTSTANDING in flight, in-order responses; Wishbone writes return err.
`timescale 1ns/1ps
module wb_axi_rd_bridge #(
  parameter int ADDR_WIDTH  = 28,
  parameter int OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_axi_rd_bridge_if.slave bus
);
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(OUTSTANDING);

  logic          arvalid_q, arvalid_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drain_q, drain_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_r_q, dat_r_d;
  logic          rready_q, rready_d;

  logic stall, accept, rd_acc, wr_acc, r_beat, resp_en, busy;
  logic unused_inputs;

  assign unused_inputs = ^{bus.wbs_dat_w, bus.wbs_sel, bus.m_axi_rlast};

  assign busy = (count_q != '0) | arvalid_q;

  // Writes wait until no read is outstanding so their err stays in order.
  always_comb begin
    stall = !rst_n
          | (arvalid_q & ~bus.m_axi_arready)
          | (count_q == MAX_CNT)
          | drain_q
          | (bus.wbs_we & busy);
  end

  assign accept = bus.wbs_cyc & bus.wbs_stb & ~stall;
  assign rd_acc = accept & ~bus.wbs_we;
  assign wr_acc = accept & bus.wbs_we;
  assign r_beat = bus.m_axi_rvalid & rready_q & (count_q != '0);

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    if (rd_acc) begin
      arvalid_d = 1'b1;
      araddr_d  = 32'({bus.wbs_adr, 2'b00});
    end else if (bus.m_axi_arready) begin
      arvalid_d = 1'b0;
    end

    count_d = count_q;
    if (rd_acc && !r_beat)      count_d = count_q + CW'(1);
    else if (!rd_acc && r_beat) count_d = count_q - CW'(1);

    drain_d = drain_q;
    if (!bus.wbs_cyc && busy) drain_d = 1'b1;
    else if (!busy)           drain_d = 1'b0;

    resp_en  = r_beat & ~drain_q & bus.wbs_cyc;
    ack_d    = resp_en & ~bus.m_axi_rresp[1];
    err_d    = (resp_en & bus.m_axi_rresp[1]) | wr_acc;
    dat_r_d  = ack_d ? bus.m_axi_rdata : '0;
    rready_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      count_q   <= '0;
      drain_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_r_q   <= '0;
      rready_q  <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      count_q   <= count_d;
      drain_q   <= drain_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_r_q   <= dat_r_d;
      rready_q  <= rready_d;
    end
  end

  assign bus.wbs_stall     = stall;
  assign bus.wbs_ack       = ack_q;
  assign bus.wbs_err       = err_q;
  assign bus.wbs_dat_r     = dat_r_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_arlen   = 8'd0;
  assign bus.m_axi_arsize  = 3'b010;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arcache = 4'b0011;
  assign bus.m_axi_rready  = rready_q;
endmodule

// File: doc/wb_axi_rd_bridge.md
Name: wb_axi_rd_bridge

Overview:
Read-only pipelined Wishbone slave that converts each Wishbone read into a single-beat AXI4 read on an AXI master port. It lets Wishbone masters fetch bitstream and status words from AXI-attached memory, and is the reverse of the AXI-read-slave-to-Wishbone-master path that feeds the DFX controller. Up to OUTSTANDING reads are in flight at once. Responses return in order. Writes are rejected with wbs_err.

Parameters:
ADDR_WIDTH, 28, Wishbone word-address width; AXI byte address = {wbs_adr, 2'b00}, zero-extended to 32 bits.
OUTSTANDING, 4, maximum AXI reads in flight; power of 2, range 1..16.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous, active-low reset.
wbs_adr  in  ADDR_WIDTH  word address.
wbs_dat_w  in  32  ignored.
wbs_dat_r  out  32  read data, valid with wbs_ack.
wbs_sel  in  4  ignored; reads are always full-word.
wbs_we  in  1  write enable; writes are errored.
wbs_cyc  in  1  bus cycle.
wbs_stb  in  1  request strobe.
wbs_stall  out  1  request not accepted this cycle.
wbs_ack  out  1  read response.
wbs_err  out  1  error response.
m_axi_araddr  out  32  read byte address.
m_axi_arlen  out  8  constant 0.
m_axi_arsize  out  3  constant 3'b010.
m_axi_arburst  out  2  constant INCR (2'b01).
m_axi_arprot  out  3  constant 0.
m_axi_arcache  out  4  constant 4'b0011.
m_axi_arvalid  out  1  address valid.
m_axi_arready  in  1  address accepted.
m_axi_rdata  in  32  read data.
m_axi_rresp  in  2  response; rresp[1]=1 means error.
m_axi_rlast  in  1  ignored (single-beat transfers).
m_axi_rvalid  in  1  data valid.
m_axi_rready  out  1  data ready.

Behaviour:
- Reset values (rst_n low, asynchronous): wbs_ack=0, wbs_err=0, wbs_dat_r=0, m_axi_arvalid=0, m_axi_araddr=0, pending count=0, drain flag=0. wbs_stall=1 while in reset.
- Accept condition: accept = wbs_cyc & wbs_stb & ~wbs_stall.
- Stall (combinational) asserts when any of these holds:
  - m_axi_arvalid & ~m_axi_arready;
  - count==OUTSTANDING;
  - drain flag set;
  - wbs_we=1 and (count!=0 or m_axi_arvalid=1), so the write error stays in order behind pending reads.
- Read accept: next cycle m_axi_arvalid=1 and m_axi_araddr={wbs_adr,2'b00}. arvalid and araddr hold until arready. A new accept in the arready cycle reloads the register, so back-to-back issue is 1 address per clock.
- Count: +1 on read accept, -1 on R beat (rvalid&rready). A simultaneous +1/-1 leaves it unchanged. The count never exceeds OUTSTANDING or wraps below 0.
- m_axi_rready = 1 at all times after reset. The count bound guarantees every accepted response has a slot.
- Response: on an R beat with drain=0, the next cycle has:
  - rresp[1]=0: wbs_ack=1 and wbs_dat_r=rdata;
  - rresp[1]=1: wbs_err=1 and wbs_dat_r=0.
  - Pulses last 1 cycle; one response per R beat, in order.
- Latency: accept at N, arvalid at N+1, arready at N+1, rvalid at N+2 gives ack at N+3.
- Write accept: no AXI activity; wbs_err=1 in the next cycle. Only accepted when count==0 and arvalid=0.
- wbs_ack and wbs_err are never both 1.
- Abort: if wbs_cyc drops while count>0 or arvalid=1, set drain.
  - Any arvalid in progress still completes (AXI rule).
  - Remaining R beats are consumed and discarded, with no ack or err.
  - Drain clears when count==0 and arvalid=0.
- No acks are generated while wbs_cyc=0.
- A reset mid-operation drops all state immediately. The AXI slave must be reset together with this block.

Test Plan:
1. Single read of adr 0x0000010, arready=1, rdata=0xCAFEF00D one cycle after AR → araddr=0x00000040, arlen=0, ack at accept+3, dat_r=0xCAFEF00D, no stall.
2. Burst of 8 stb back-to-back, OUTSTANDING=4, rvalid delayed 10 cycles → stall asserts after 4 accepts; all 8 acks return in order with rdata 0..7; count returns to 0.
3. arready held low 5 cycles → arvalid and araddr stable across all 5 cycles; wbs_stall=1 throughout; exactly one AR handshake.
4. Read with rresp=2'b10 → wbs_err=1 for 1 cycle, wbs_ack=0; next read with rresp=0 acks normally.
5. Write stb issued behind 2 pending reads → stalled until both acks; then wbs_err pulses once; no arvalid for the write.
6. cyc drops with 3 reads pending, then a new cycle starts → 3 R beats consumed, no acks; new stb stalled until drain clears; following read acks correctly. Then assert rst_n=0 mid-read → all outputs at reset values within the same cycle.
